// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch and data-access requesters.
// Data has priority with inst anti-starvation; an in-order owner FIFO routes each response back.
module mem_port_arbiter #(
   parameter int MAX_OUTST    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   arb_state_t           state, next_state;
   logic                 lock_data;
   logic [MAX_OUTST-1:0] owner_q;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;
   logic [STV_W-1:0]     starve_cnt;
   logic                 grant_inst, grant_data;
   logic                 full, empty, starve_hit, push, pop, head;

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full       = (count == CNT_W'(MAX_OUTST));
   assign empty      = (count == '0);
   assign starve_hit = (starve_cnt == STV_W'(STARVE_LIMIT));

   // Grant is gated by resetn so the port goes quiet the moment reset asserts.
   always_comb begin
      next_state = state;
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (resetn) begin
         case (state)
            IDLE: begin
               if (!full) begin
                  if (inst_req && (!data_req || starve_hit)) grant_inst = 1'b1;
                  else if (data_req)                         grant_data = 1'b1;
               end
               if ((grant_inst || grant_data) && !m_addr_ok) next_state = LOCKED;
            end
            LOCKED: begin
               grant_data = lock_data;
               grant_inst = !lock_data;
               if (m_addr_ok) next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         lock_data <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == LOCKED) lock_data <= grant_data;
      end
   end

   always_comb begin
      m_req   = grant_inst | grant_data;
      m_wr    = 1'b0;
      m_size  = 2'd0;
      m_addr  = 32'd0;
      m_wstrb = 4'd0;
      m_wdata = 32'd0;
      if (grant_data) begin
         m_wr    = data_wr;
         m_size  = data_size;
         m_addr  = data_addr;
         m_wstrb = data_wstrb;
         m_wdata = data_wdata;
      end else if (grant_inst) begin
         m_size  = 2'd2;
         m_addr  = inst_addr;
      end
   end

   assign inst_addr_ok = grant_inst & m_addr_ok;
   assign data_addr_ok = grant_data & m_addr_ok;
   assign push         = m_req & m_addr_ok;
   assign pop          = resetn & m_data_ok & !empty;
   assign head         = owner_q[rd_ptr];
   assign inst_data_ok = pop & !head;
   assign data_data_ok = pop & head;
   assign inst_rdata   = inst_data_ok ? m_rdata : 32'd0;
   assign data_rdata   = data_data_ok ? m_rdata : 32'd0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (push) begin
            owner_q[wr_ptr] <= grant_data;
            wr_ptr          <= inc_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= inc_ptr(rd_ptr);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (!push && pop) count <= count - CNT_W'(1);
      end
   end

   // Counts data wins that happened while inst was left waiting.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!inst_req || (push && grant_inst)) begin
         starve_cnt <= '0;
      end else if (push && grant_data && !starve_hit) begin
         starve_cnt <= starve_cnt + STV_W'(1);
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single SRAM-like memory port between the instruction-fetch requester (read-only) and the data-access requester (read/write).
- Sits between the core's fetch and memory stages and the future AXI bridge / unified memory.
- Arbitrates address-phase requests with data priority and inst anti-starvation.
- Tracks up to MAX_OUTST in-order outstanding transactions, so each data_ok and rdata is routed back to its owner.

Parameters:
- MAX_OUTST, 2, max accepted-but-unanswered transactions; power of 2, range 1..8.
- STARVE_LIMIT, 4, consecutive data grants allowed while an inst request waits; the next grant is forced to inst.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  inst read request
- inst_addr  in  32  inst address (size fixed word, 2'b10)
- inst_addr_ok  out  1  inst address phase accepted this cycle
- inst_data_ok  out  1  inst read data valid this cycle
- inst_rdata  out  32  inst read data
- data_req  in  1  data request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wstrb  in  4  byte strobes
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address phase accepted this cycle
- data_data_ok  out  1  data read data valid or write done this cycle
- data_rdata  out  32  data read data
- m_req  out  1  downstream request
- m_wr, m_size, m_addr, m_wstrb, m_wdata  out  1/2/32/4/32  downstream request fields
- m_addr_ok  in  1  downstream address accepted
- m_data_ok  in  1  downstream response, in request order
- m_rdata  in  32  downstream read data

Behaviour:
- Reset (resetn low, async): owner FIFO empty, lock clear, grant=none, starve_cnt=0.
  - Outputs: m_req=0, all *_addr_ok=0, *_data_ok=0, rdata outputs 0.
  - Takes effect immediately, mid-transaction included. Downstream is reset by the same resetn.
- Handshake: a transfer occurs when m_req && m_addr_ok in the same cycle. The requester sees its *_addr_ok in that cycle.
- Requesters keep req and fields stable until addr_ok; requests are not withdrawn.
- Arbiter states: IDLE (no lock) and LOCKED (m_req asserted, m_addr_ok not yet seen).
  - IDLE: if FIFO not full and any req is pending, grant combinationally.
  - Grant priority: data over inst, except inst wins when starve_cnt==STARVE_LIMIT and inst_req=1.
  - IDLE -> LOCKED when m_req=1 and m_addr_ok=0.
  - LOCKED: grant and m_* fields held from the locked requester; the new requester is ignored. Return to IDLE on m_addr_ok.
- m_* fields mux from the granted requester.
  - Inst grant drives m_wr=0, m_size=2, m_wstrb=0, m_wdata=0.
  - No grant drives all m_* fields 0.
- FIFO full (count==MAX_OUTST): m_req=0, no grant.
  - A push in the same cycle as a pop is disallowed when full; acceptance resumes the cycle after the pop.
  - A lock is never formed while full.
- Owner FIFO: 1-bit entry (1=data) pushed on each transfer, popped on each m_data_ok.
  - Push and pop in the same cycle (not full) leave the count unchanged.
  - Pointers wrap modulo MAX_OUTST.
- Response routing is combinational, same cycle as m_data_ok:
  - head=0: inst_data_ok=1, inst_rdata=m_rdata.
  - head=1: data_data_ok=1, data_rdata=m_rdata.
  - The other side's data_ok is 0 and its rdata is 0.
  - m_data_ok with FIFO empty is ignored (no output, no pop).
- starve_cnt:
  - Increments on a data transfer while inst_req=1, saturating at STARVE_LIMIT.
  - Clears on an inst transfer, or in any cycle inst_req=0.
- Latency: zero added cycles. addr_ok is combinational from m_addr_ok; data_ok is combinational from m_data_ok.
- Back-to-back transfers are allowed every cycle while the FIFO has room.

Test Plan:
- Inst only: inst_req, addr 0x1c000000; m_addr_ok=1 at once; m_data_ok 2 cycles later with m_rdata=0x02800421.
  - Expect: m_wr=0, m_size=2, inst_addr_ok 1 cycle, inst_data_ok=1 with rdata 0x02800421, data_data_ok=0.
- Simultaneous requests: data write (addr 0x1c001000, wstrb 4'hf, wdata 0xdeadbeef) and inst read, both in the same cycle, m_addr_ok always 1.
  - Expect: data transfers first, inst in the next cycle.
  - Two m_data_ok pulses: the first raises data_data_ok, the second raises inst_data_ok.
- Lock: data granted with m_addr_ok=0 for 3 cycles; inst_req rises in cycle 1.
  - Expect: m_addr stays 0x1c001000 and m_wr stays 1 throughout.
  - data_addr_ok only in cycle 4; inst granted in cycle 5.
- Full: MAX_OUTST=2, two reads accepted, no m_data_ok, third request pending.
  - Expect: m_req=0.
  - One m_data_ok: m_req stays 0 that cycle, third accepted the next cycle.
- Starvation: data_req held high and inst_req high, m_addr_ok=1, m_data_ok returned each cycle.
  - Expect: 4 data transfers, then an inst transfer on the 5th grant, then data again.
- Reset mid-operation: resetn low with 2 outstanding and a lock active.
  - Expect: m_req and all ok signals 0 in the same cycle.
  - After release, a new inst read completes normally and the FIFO count starts from 0.
